// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with input synchronisers, a shared-prescaler
// debounce filter, and edge-triggered interrupts.
//
// Ports:
//   clk_i, rst_i           clock and synchronous active-high reset
//   mem_valid_i/we_i       register access request and direction (1 = write)
//   mem_addr_i             word index into the register map
//   mem_wdata_i            write data
//   mem_rdata_o            read data, valid while mem_ready_o is high
//   mem_ready_o            one-cycle access-complete pulse
//   gpio_in_i              raw asynchronous pad inputs
//   gpio_out_o             pad output data (OUT register)
//   gpio_outenb_o          active-low output enable (OENB register)
//   gpio_pullupb_o         active-low pull-up enable (PUB register)
//   gpio_pulldownb_o       active-low pull-down enable (PDB register)
//   irq_o                  registered level interrupt
//
// Register map (word index): 0 OUT, 1 OENB, 2 PUB, 3 PDB, 4 IN (RO),
// 5 IRQ_EN, 6 IRQ_RISE, 7 IRQ_FALL, 8 IRQ_STAT (W1C), 9 DBNC.
module gpio_bank #(
  parameter int GPIO_NUM    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DBNC_W      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_valid_i,
  input  logic                mem_we_i,
  input  logic [3:0]          mem_addr_i,
  input  logic [31:0]         mem_wdata_i,
  output logic [31:0]         mem_rdata_o,
  output logic                mem_ready_o,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  output logic [GPIO_NUM-1:0] gpio_out_o,
  output logic [GPIO_NUM-1:0] gpio_outenb_o,
  output logic [GPIO_NUM-1:0] gpio_pullupb_o,
  output logic [GPIO_NUM-1:0] gpio_pulldownb_o,
  output logic                irq_o
);

  // Register state
  logic [GPIO_NUM-1:0] out_reg, oenb_reg, pub_reg, pdb_reg;
  logic [GPIO_NUM-1:0] en_reg, rise_reg, fall_reg, stat_reg;
  logic [DBNC_W-1:0]   dbnc_reg, cnt_reg;
  logic [GPIO_NUM-1:0] f_reg, last_reg;
  logic [GPIO_NUM-1:0] sync_reg [SYNC_STAGES];
  logic                ready_reg, irq_reg;
  logic [31:0]         rdata_reg;

  // Next-state / combinational signals
  logic [GPIO_NUM-1:0] s_sync;
  logic [GPIO_NUM-1:0] f_next, last_next, set_evt, stat_next, w1c_mask;
  logic [DBNC_W-1:0]   cnt_next;
  logic [15:0]         wr_sel;
  logic [GPIO_NUM-1:0] wdata_g;
  logic [31:0]         rd_word;
  logic                access, wr_en, tick, dbnc_off;
  logic                unused_wdata;

  // An access is accepted on the first sampled cycle of valid; the ready
  // pulse that follows blocks re-acceptance while the master drops valid.
  assign access  = mem_valid_i & ~ready_reg;
  assign wr_en   = access & mem_we_i;
  assign wr_sel  = wr_en ? (16'd1 << mem_addr_i) : 16'd0;
  assign wdata_g = mem_wdata_i[GPIO_NUM-1:0];
  assign unused_wdata = &{1'b0, mem_wdata_i};

  assign s_sync   = sync_reg[SYNC_STAGES-1];
  assign dbnc_off = (dbnc_reg == '0);
  assign tick     = ~dbnc_off & (cnt_reg == dbnc_reg);

  // Prescaler counts 0..N; a DBNC write restarts it from 0.
  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (wr_sel[9] || dbnc_off || tick) begin
      cnt_next = '0;
    end
  end

  assign last_next = tick ? s_sync : last_reg;
  assign w1c_mask  = wr_sel[8] ? wdata_g : '0;
  // A coincident edge event wins over a W1C clear of the same bit.
  assign stat_next = (stat_reg & ~w1c_mask) | set_evt;

  // Synchroniser chain
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync_reg[gi] <= '0;
        end else if (gi == 0) begin
          sync_reg[gi] <= gpio_in_i;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  // Per-pin filter and edge detect. With debounce active, a pin only moves
  // when two consecutive ticks sampled the same new value.
  generate
    for (genvar gi = 0; gi < GPIO_NUM; gi++) begin : g_pin
      assign f_next[gi]  = dbnc_off ? s_sync[gi] :
                           (tick && (s_sync[gi] == last_reg[gi])) ? s_sync[gi] : f_reg[gi];
      assign set_evt[gi] = (f_next[gi] & ~f_reg[gi] & rise_reg[gi]) |
                           (~f_next[gi] & f_reg[gi] & fall_reg[gi]);
    end
  endgenerate

  // Read mux; unmapped indices and bits above the pin count read as zero.
  always_comb begin
    rd_word = '0;
    case (mem_addr_i)
      4'd0: rd_word[GPIO_NUM-1:0] = out_reg;
      4'd1: rd_word[GPIO_NUM-1:0] = oenb_reg;
      4'd2: rd_word[GPIO_NUM-1:0] = pub_reg;
      4'd3: rd_word[GPIO_NUM-1:0] = pdb_reg;
      4'd4: rd_word[GPIO_NUM-1:0] = f_reg;
      4'd5: rd_word[GPIO_NUM-1:0] = en_reg;
      4'd6: rd_word[GPIO_NUM-1:0] = rise_reg;
      4'd7: rd_word[GPIO_NUM-1:0] = fall_reg;
      4'd8: rd_word[GPIO_NUM-1:0] = stat_reg;
      4'd9: rd_word[DBNC_W-1:0]   = dbnc_reg;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_reg   <= '0;
      oenb_reg  <= '1;
      pub_reg   <= '1;
      pdb_reg   <= '1;
      en_reg    <= '0;
      rise_reg  <= '0;
      fall_reg  <= '0;
      stat_reg  <= '0;
      dbnc_reg  <= '0;
      cnt_reg   <= '0;
      f_reg     <= '0;
      last_reg  <= '0;
      ready_reg <= 1'b0;
      rdata_reg <= '0;
      irq_reg   <= 1'b0;
    end else begin
      if (wr_sel[0]) out_reg  <= wdata_g;
      if (wr_sel[1]) oenb_reg <= wdata_g;
      if (wr_sel[2]) pub_reg  <= wdata_g;
      if (wr_sel[3]) pdb_reg  <= wdata_g;
      if (wr_sel[5]) en_reg   <= wdata_g;
      if (wr_sel[6]) rise_reg <= wdata_g;
      if (wr_sel[7]) fall_reg <= wdata_g;
      if (wr_sel[9]) dbnc_reg <= mem_wdata_i[DBNC_W-1:0];
      cnt_reg   <= cnt_next;
      f_reg     <= f_next;
      last_reg  <= last_next;
      stat_reg  <= stat_next;
      ready_reg <= access;
      rdata_reg <= access ? rd_word : '0;
      // Uses the current STAT/EN, so irq trails STAT by one cycle.
      irq_reg   <= |(stat_reg & en_reg);
    end
  end

  assign mem_ready_o      = ready_reg;
  assign mem_rdata_o      = rdata_reg;
  assign gpio_out_o       = out_reg;
  assign gpio_outenb_o    = oenb_reg;
  assign gpio_pullupb_o   = pub_reg;
  assign gpio_pulldownb_o = pdb_reg;
  assign irq_o            = irq_reg;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed and randomized checks of gpio_bank against a
// cycle-level behavioural model of the register map, debounce and interrupts.
module tb_gpio_bank;
  localparam int G    = 16;
  localparam int SYNC = 2;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid, mem_we;
  logic [3:0]    mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_ready;
  logic [G-1:0]  gpio_in, gpio_out, gpio_oenb, gpio_pub, gpio_pdb;
  logic          irq;

  always #5 clk = ~clk;

  gpio_bank #(.GPIO_NUM(G), .SYNC_STAGES(SYNC), .DBNC_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_valid_i(mem_valid), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
    .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .gpio_outenb_o(gpio_oenb),
    .gpio_pullupb_o(gpio_pub), .gpio_pulldownb_o(gpio_pdb), .irq_o(irq)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  logic [G-1:0]  m_out, m_oenb, m_pub, m_pdb, m_en, m_rise, m_fall, m_stat, m_f, m_last;
  logic [DW-1:0] m_dbnc;
  int            m_cnt;
  logic          m_ready, m_irq, m_rd_valid;
  logic [31:0]   m_rdata;
  logic [G-1:0]  hist[$];   // pad samples, newest first; s is SYNC edges old

  task automatic model_reset();
    m_out = '0; m_oenb = '1; m_pub = '1; m_pdb = '1;
    m_en = '0; m_rise = '0; m_fall = '0; m_stat = '0;
    m_f = '0; m_last = '0; m_dbnc = '0; m_cnt = 0;
    m_ready = 1'b0; m_irq = 1'b0; m_rd_valid = 1'b0; m_rdata = '0;
    hist.delete();
    repeat (SYNC) hist.push_back('0);
  endtask

  // Advance the model by one clock edge using the inputs currently driven,
  // then let the DUT take the same edge and compare its outputs.
  task automatic step();
    logic [G-1:0] s, f_n, set_m, clr;
    logic         acc, new_irq;
    logic [31:0]  rd;
    if (rst) begin
      model_reset();
    end else begin
      s = hist[SYNC-1];
      hist.push_front(gpio_in);
      hist.delete(SYNC);
      acc     = mem_valid && !m_ready;
      new_irq = |(m_stat & m_en);
      f_n = m_f;
      if (m_dbnc == 0) begin
        f_n = s;
        m_cnt = 0;
      end else if (m_cnt == int'(m_dbnc)) begin
        for (int i = 0; i < G; i++)
          if (s[i] == m_last[i] && s[i] != m_f[i]) f_n[i] = s[i];
        m_last = s;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      set_m = '0;
      for (int i = 0; i < G; i++) begin
        if (f_n[i] && !m_f[i] && m_rise[i]) set_m[i] = 1'b1;
        if (!f_n[i] && m_f[i] && m_fall[i]) set_m[i] = 1'b1;
      end
      rd = '0;
      case (mem_addr)
        4'd0: rd = 32'(m_out);
        4'd1: rd = 32'(m_oenb);
        4'd2: rd = 32'(m_pub);
        4'd3: rd = 32'(m_pdb);
        4'd4: rd = 32'(m_f);
        4'd5: rd = 32'(m_en);
        4'd6: rd = 32'(m_rise);
        4'd7: rd = 32'(m_fall);
        4'd8: rd = 32'(m_stat);
        4'd9: rd = 32'(m_dbnc);
        default: rd = '0;
      endcase
      clr = '0;
      if (acc && mem_we) begin
        case (mem_addr)
          4'd0: m_out  = mem_wdata[G-1:0];
          4'd1: m_oenb = mem_wdata[G-1:0];
          4'd2: m_pub  = mem_wdata[G-1:0];
          4'd3: m_pdb  = mem_wdata[G-1:0];
          4'd5: m_en   = mem_wdata[G-1:0];
          4'd6: m_rise = mem_wdata[G-1:0];
          4'd7: m_fall = mem_wdata[G-1:0];
          4'd8: clr    = mem_wdata[G-1:0];
          4'd9: begin m_dbnc = mem_wdata[DW-1:0]; m_cnt = 0; end
          default: ;
        endcase
      end
      m_stat     = (m_stat & ~clr) | set_m;
      m_f        = f_n;
      m_irq      = new_irq;
      m_ready    = acc;
      m_rd_valid = acc && !mem_we;
      m_rdata    = rd;
    end
    @(posedge clk);
    #1;
    check_val("ready", 32'(mem_ready), 32'(m_ready));
    if (m_rd_valid) check_val("rdata", mem_rdata, m_rdata);
    check_val("gpio_out", 32'(gpio_out), 32'(m_out));
    check_val("gpio_oenb", 32'(gpio_oenb), 32'(m_oenb));
    check_val("gpio_pub", 32'(gpio_pub), 32'(m_pub));
    check_val("gpio_pdb", 32'(gpio_pdb), 32'(m_pdb));
    check_val("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    mem_valid = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    step();
    check_val("wr_ready_hi", 32'(mem_ready), 32'd1);
    mem_valid = 1'b0; mem_we = 1'b0;
    step();
    check_val("wr_ready_lo", 32'(mem_ready), 32'd0);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    mem_valid = 1'b1; mem_we = 1'b0; mem_addr = a; mem_wdata = '0;
    step();
    d = mem_rdata;
    mem_valid = 1'b0;
    step();
  endtask

  logic [31:0] d;
  logic [31:0] exp_rst [10];

  initial begin
    exp_rst = '{32'h0, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    gpio_in = '0;
    model_reset();
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check_val("rst_out", 32'(gpio_out), 32'h0);
    check_val("rst_oenb", 32'(gpio_oenb), 32'hFFFF);
    check_val("rst_pub", 32'(gpio_pub), 32'hFFFF);
    check_val("rst_pdb", 32'(gpio_pdb), 32'hFFFF);
    check_val("rst_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 10; i++) begin
      bus_read(4'(i), d);
      check_val($sformatf("rst_rd%0d", i), d, exp_rst[i]);
    end
    bus_read(4'd15, d);
    check_val("rst_rd15", d, 32'h0);

    // Unmapped / read-only / upper bits
    bus_write(4'd12, 32'hDEAD_BEEF);
    bus_read(4'd12, d);
    check_val("unmapped_rd", d, 32'h0);
    bus_write(4'd4, 32'hFFFF);
    bus_read(4'd4, d);
    check_val("in_ro", d, 32'h0);
    bus_write(4'd1, 32'h1234_FFFF);
    bus_read(4'd1, d);
    check_val("oenb_upper", d, 32'h0000_FFFF);

    // Output registers drive the pads
    bus_write(4'd0, 32'hA5A5);
    check_val("out_a5a5", 32'(gpio_out), 32'hA5A5);
    bus_write(4'd1, 32'h00FF);
    check_val("oenb_00ff", 32'(gpio_oenb), 32'h00FF);

    // Bypass filter: rise on pin 0 with interrupt enabled
    bus_write(4'd6, 32'h1);
    bus_write(4'd5, 32'h1);
    step();
    gpio_in[0] = 1'b1;
    step(); step();
    step();
    check_val("irq_k3", 32'(irq), 32'h0);
    step();
    check_val("irq_k4", 32'(irq), 32'h1);
    bus_read(4'd4, d);
    check_val("in0_set", d & 32'h1, 32'h1);
    bus_read(4'd8, d);
    check_val("stat0_set", d, 32'h1);
    bus_write(4'd8, 32'h1);
    check_val("irq_cleared", 32'(irq), 32'h0);

    // Debounce N=9: short pulse rejected, long level accepted
    bus_write(4'd9, 32'd9);
    bus_write(4'd6, 32'h9);
    gpio_in[3] = 1'b1;
    repeat (5) step();
    gpio_in[3] = 1'b0;
    repeat (30) step();
    bus_read(4'd4, d);
    check_val("pulse_in3", (d >> 3) & 32'h1, 32'h0);
    bus_read(4'd8, d);
    check_val("pulse_stat", d, 32'h0);
    gpio_in[3] = 1'b1;
    repeat (22) step();
    bus_read(4'd4, d);
    check_val("held_in3", (d >> 3) & 32'h1, 32'h1);
    bus_read(4'd8, d);
    check_val("held_stat3", (d >> 3) & 32'h1, 32'h1);

    // Falling edge on pin 5 coincident with a W1C of bit 5: set wins
    bus_write(4'd9, 32'd0);
    bus_write(4'd7, 32'h20);
    gpio_in[5] = 1'b1;
    repeat (5) step();
    bus_write(4'd8, 32'hFFFF);
    gpio_in[5] = 1'b0;
    step(); step();
    mem_valid = 1'b1; mem_we = 1'b1; mem_addr = 4'd8; mem_wdata = 32'h20;
    step();
    mem_valid = 1'b0; mem_we = 1'b0;
    step();
    bus_read(4'd8, d);
    check_val("set_wins", (d >> 5) & 32'h1, 32'h1);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      logic [3:0] a;
      if ($urandom_range(0, 5) == 0) gpio_in[$urandom_range(0, G-1)] ^= 1'b1;
      r = $urandom_range(0, 3);
      a = 4'($urandom_range(0, 15));
      if (r == 0) begin
        if (a == 4'd9) bus_write(a, 32'($urandom_range(0, 4)));
        else           bus_write(a, $urandom);
      end else if (r == 1) begin
        bus_read(a, d);
      end else begin
        step();
      end
    end

    // Reset during a held write, with irq active beforehand
    bus_write(4'd9, 32'd0);
    bus_write(4'd6, 32'hFFFF);
    bus_write(4'd7, 32'hFFFF);
    bus_write(4'd5, 32'hFFFF);
    gpio_in[0] = ~gpio_in[0];
    repeat (5) step();
    check_val("irq_pre_rst", 32'(irq), 32'h1);
    mem_valid = 1'b1; mem_we = 1'b1; mem_addr = 4'd0; mem_wdata = 32'hFFFF;
    rst = 1'b1;
    step();
    check_val("rst_ready", 32'(mem_ready), 32'h0);
    check_val("rst_out_clr", 32'(gpio_out), 32'h0);
    check_val("rst_irq_clr", 32'(irq), 32'h0);
    rst = 1'b0; mem_valid = 1'b0; mem_we = 1'b0;
    step();
    check_val("no_ready_after_rst", 32'(mem_ready), 32'h0);
    repeat (6) step();
    bus_read(4'd8, d);
    check_val("no_stat_after_rst", d, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
